param_accumulator: RTL and testbench
====================================

Name: param_accumulator

Overview:
Parametrised sequential adder that sums a fixed number of unsigned operands into one result. Input and output both use a valid/ready handshake. Overflow handling (wrap or saturate) is selected by a parameter, and a sticky overflow flag is reported with each result. It is the streaming, multi-operand successor to the combinational WIDTH-parametrised adder, intended for datapath reduction stages.

Parameters:
WIDTH, 8, operand and result width in bits (>=1)
COUNT, 4, operands summed per result (>=1)
SATURATE, 0, 0 = result wraps modulo 2^WIDTH; 1 = result clamps at 2^WIDTH-1
localparam CW = $clog2(COUNT+1), width of the operand counter; not overridable

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous abort: discards the partial sum or the pending result
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept an operand
in_data  input  WIDTH  unsigned operand
out_valid  output  1  result is valid
out_ready  input  1  downstream accepts the result
out_sum  output  WIDTH  accumulated result
out_ovf  output  1  at least one addition in this result overflowed
count  output  CW  operands accepted toward the current result

Behaviour:
- Reset (async assert; release synchronous to clk): state=ACCUM, acc=0, count=0, ovf=0. Outputs: out_valid=0, out_sum=0, out_ovf=0, in_ready=1.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1, out_sum/out_ovf stable.
- ACCUM, input accepted (in_valid & in_ready):
  - Compute s = acc + in_data in WIDTH+1 bits; carry c = s[WIDTH].
  - Wrap: acc <= s[WIDTH-1:0].
  - Saturate: acc <= c ? all-ones : s[WIDTH-1:0]. Once acc is all-ones it stays all-ones.
  - ovf <= ovf | c; count <= count+1.
- ACCUM -> HOLD on the edge that accepts operand number COUNT.
  - out_valid rises on the next cycle, i.e. latency is 1 cycle from the last operand.
  - count stays at COUNT while in HOLD.
- HOLD -> ACCUM on out_valid & out_ready. acc, count and ovf clear on that edge; in_ready=1 the next cycle.
  - No operand is accepted in the handover cycle, so throughput is COUNT+1 cycles per result with no backpressure.
- out_sum is the acc register; out_ovf is the ovf register. Both are meaningful only while out_valid=1.
  - Wrap: out_sum = Σ in_data mod 2^WIDTH.
  - Saturate: out_sum = min(Σ, 2^WIDTH-1).
- clr (synchronous, highest priority after rst):
  - In any state, next state=ACCUM with acc=0, count=0, ovf=0.
  - An operand presented in the clr cycle is not accepted (in_ready forced 0 that cycle).
  - A result in HOLD is discarded even if out_ready=1 in the same cycle.
- COUNT=1: every accepted operand goes directly to HOLD; out_sum = operand, out_ovf=0.
- in_valid while in HOLD: ignored, no operand consumed; the upstream must hold its data.
- out_ready while in ACCUM: ignored.
- rst asserted mid-accumulation or mid-HOLD: immediate return to reset values; the partial or pending result is lost.
- in_data is don't-care when in_valid=0. No X may propagate into acc from an unaccepted cycle.

Test Plan:
1. WIDTH=8, COUNT=4, SATURATE=0; feed 2,3,5,7 back-to-back, out_ready=1 -> out_valid for exactly 1 cycle, 1 cycle after the 4th accept; out_sum=17, out_ovf=0; in_ready=0 during HOLD, 1 again the following cycle.
2. Wrap overflow: feed 200,100,0,0 -> out_sum=44, out_ovf=1. Same stimulus with SATURATE=1 -> out_sum=255, out_ovf=1. Saturate with 255,1,0,3 -> 255, ovf=1.
3. Backpressure: after result 17, hold out_ready=0 for 3 cycles with in_valid=1 and in_data=9 -> in_ready=0, out_sum stays 17, count=4. Then out_ready=1 -> next result begins with operand 9.
4. Gapped input: in_valid toggles 1,0,0,1,1,0,1 carrying 1,x,x,2,3,x,4 -> out_sum=10; count steps 1,1,1,2,3,3,4.
5. clr after 2 operands (10,20), then feed 1,1,1,1 -> out_sum=4. clr during HOLD with out_ready=1 -> no handshake completes; out_valid=0 next cycle.
6. rst pulsed asynchronously mid-cycle after 3 operands -> outputs go to reset values immediately; next 4 operands 5,5,5,5 -> out_sum=20, out_ovf=0. Also COUNT=1: operand 77 -> out_sum=77.

Source files
------------

// File: rtl/param_accumulator.sv
// param_accumulator: streaming multi-operand adder.
// Sums COUNT unsigned WIDTH-bit operands into one result, with valid/ready
// handshakes on both sides. Overflow either wraps or clamps (SATURATE). A
// sticky flag records whether any addition within the current result carried.
module param_accumulator #(
   parameter int WIDTH    = 8,
   parameter int COUNT    = 4,
   parameter bit SATURATE = 1'b0,
   localparam int CW      = $clog2(COUNT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_ovf,
   output logic [CW-1:0]    count
);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   // Value of the operand counter when the final operand of a result arrives.
   localparam logic [CW-1:0] LAST_IDX = CW'(COUNT - 1);

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic             ovf;
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   sum;
   logic             carry;
   logic [WIDTH-1:0] acc_next;
   logic             accept;

   // Next accumulator value for an accepted operand, with optional clamping.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
      sum      = {1'b0, acc} + {1'b0, in_data};
      carry    = sum[WIDTH];
      acc_next = sum[WIDTH-1:0];
      if (SATURATE && carry) begin
         acc_next = '1;
      end
   end

   // Operands are taken only while accumulating; an abort cycle refuses them.
   assign in_ready = (state == ACCUM) && !clr;
   assign accept   = in_valid && in_ready;

   assign out_valid = (state == HOLD);
   assign out_sum   = acc;
   assign out_ovf   = ovf;
   assign count     = cnt;

   // Control FSM plus accumulator, overflow flag and operand counter.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
      if (rst) begin
         state <= ACCUM;
         acc   <= '0;
         ovf   <= 1'b0;
         cnt   <= '0;
      end else if (clr) begin
         state <= ACCUM;
         acc   <= '0;
         ovf   <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            ACCUM: begin
               // NOTE: acc only loads on an accepted operand, so don't-care input data can never reach it.
               if (accept) begin
                  acc <= acc_next;
                  ovf <= ovf | carry;
                  cnt <= cnt + CW'(1);
                  if (cnt == LAST_IDX) begin
                     state <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state <= ACCUM;
                  acc   <= '0;
                  ovf   <= 1'b0;
                  cnt   <= '0;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_param_accumulator.sv
// Testbench for param_accumulator: wrap and saturate instances share one
// stimulus stream and are scored against a queue of expected results; a third
// instance exercises COUNT=1.
module tb_param_accumulator;

   typedef struct packed {
      logic [7:0] sum;
      logic       ovf;
   } res_t;

   logic       clk;
   logic       rst;
   logic       clr;
   logic       in_valid;
   logic [7:0] in_data;
   logic       out_ready;

   logic       in_ready,   out_valid,   out_ovf;
   logic [7:0] out_sum;
   logic [2:0] count;

   logic       s_in_ready, s_out_valid, s_out_ovf;
   logic [7:0] s_out_sum;
   logic [2:0] s_count;

   logic       c1_in_valid, c1_out_ready;
   logic [7:0] c1_in_data;
   logic       c1_in_ready, c1_out_valid, c1_out_ovf;
   logic [7:0] c1_out_sum;
   logic [0:0] c1_count;

   int   total = 0;
   int   bad   = 0;
   res_t q_w[$];
   res_t q_s[$];

   param_accumulator #(.WIDTH(8), .COUNT(4), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_ovf(out_ovf), .count(count)
   );

   param_accumulator #(.WIDTH(8), .COUNT(4), .SATURATE(1'b1)) u_sat (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
      .out_valid(s_out_valid), .out_ready(out_ready),
      .out_sum(s_out_sum), .out_ovf(s_out_ovf), .count(s_count)
   );

   param_accumulator #(.WIDTH(8), .COUNT(1), .SATURATE(1'b0)) u_one (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(c1_in_valid), .in_ready(c1_in_ready), .in_data(c1_in_data),
      .out_valid(c1_out_valid), .out_ready(c1_out_ready),
      .out_sum(c1_out_sum), .out_ovf(c1_out_ovf), .count(c1_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected results for a group of operands whose plain sum is s.
   task automatic push_exp(input int s);
      res_t w, t;
      w.sum = s[7:0];
      w.ovf = (s > 255);
      t.sum = (s > 255) ? 8'hff : s[7:0];
      t.ovf = (s > 255);
      q_w.push_back(w);
      q_s.push_back(t);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one operand and hold it until accepted (bounded).
   task automatic send(input logic [7:0] d);
      int   n;
      logic took;
      in_valid = 1'b1;
      in_data  = d;
      n        = 0;
      took     = 1'b0;
      while (!took && n < 20) begin
         @(negedge clk);
         took = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      check("send_accepted", took, 1'b1);
      in_valid = 1'b0;
      in_data  = 8'hxx;
   endtask

   // Scoreboard for the wrapping instance.
   always @(negedge clk) begin : mon_wrap
      res_t e;
      if (!rst && !clr && out_valid && out_ready) begin
         if (q_w.size() == 0) begin
            check("wrap_unexpected_result", out_valid, 1'b0);
         end else begin
            e = q_w.pop_front();
            check("wrap_sum", out_sum, e.sum);
            check("wrap_ovf", out_ovf, e.ovf);
         end
      end
   end

   // Scoreboard for the saturating instance.
   always @(negedge clk) begin : mon_sat
      res_t e;
      if (!rst && !clr && s_out_valid && out_ready) begin
         if (q_s.size() == 0) begin
            check("sat_unexpected_result", s_out_valid, 1'b0);
         end else begin
            e = q_s.pop_front();
            check("sat_sum", s_out_sum, e.sum);
            check("sat_ovf", s_out_ovf, e.ovf);
         end
      end
   end

   initial begin
      logic       gap_v[7];
      logic [7:0] gap_d[7];
      logic [2:0] gap_c[7];
      gap_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      gap_d = '{8'd1, 8'hxx, 8'hxx, 8'd2, 8'd3, 8'hxx, 8'd4};
      gap_c = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4};

      rst          = 1'b1;
      clr          = 1'b0;
      in_valid     = 1'b0;
      in_data      = 8'hxx;
      out_ready    = 1'b1;
      c1_in_valid  = 1'b0;
      c1_in_data   = 8'hxx;
      c1_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_sum", out_sum, 8'd0);
      check("rst_out_ovf", out_ovf, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_count", count, 3'd0);
      @(posedge clk);
      #1;

      // Basic sum with one-cycle latency and single-cycle out_valid
      push_exp(17);
      send(8'd2);
      send(8'd3);
      send(8'd5);
      send(8'd7);
      @(negedge clk);
      check("t1_out_valid_hold", out_valid, 1'b1);
      check("t1_in_ready_hold", in_ready, 1'b0);
      @(posedge clk);
      #1;
      check("t1_out_valid_after", out_valid, 1'b0);
      check("t1_in_ready_after", in_ready, 1'b1);
      check("t1_count_after", count, 3'd0);

      // Overflow: wrap gives 44, saturate gives 255
      push_exp(300);
      send(8'd200);
      send(8'd100);
      send(8'd0);
      send(8'd0);
      idle(1);
      push_exp(259);
      send(8'd255);
      send(8'd1);
      send(8'd0);
      send(8'd3);
      idle(1);

      // Backpressure in HOLD with an operand waiting upstream
      out_ready = 1'b0;
      push_exp(17);
      send(8'd2);
      send(8'd3);
      send(8'd5);
      send(8'd7);
      in_valid = 1'b1;
      in_data  = 8'd9;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_in_ready", in_ready, 1'b0);
         check("bp_out_valid", out_valid, 1'b1);
         check("bp_out_sum", out_sum, 8'd17);
         check("bp_count", count, 3'd4);
         @(posedge clk);
         #1;
      end
      push_exp(12);
      out_ready = 1'b1;
      send(8'd9);
      send(8'd1);
      send(8'd1);
      send(8'd1);
      idle(1);

      // Gapped input with don't-care data in idle cycles
      push_exp(10);
      for (int i = 0; i < 7; i++) begin
         in_valid = gap_v[i];
         in_data  = gap_d[i];
         @(posedge clk);
         #1;
         check("gap_count", count, gap_c[i]);
      end
      in_valid = 1'b0;
      in_data  = 8'hxx;
      idle(1);

      // Abort a partial sum; the operand in the abort cycle is refused
      send(8'd10);
      send(8'd20);
      clr      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'd50;
      @(negedge clk);
      check("clr_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      clr      = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'hxx;
      check("clr_count", count, 3'd0);
      push_exp(4);
      send(8'd1);
      send(8'd1);
      send(8'd1);
      send(8'd1);
      idle(1);

      // Abort a pending result while out_ready is high
      send(8'd2);
      send(8'd2);
      send(8'd2);
      send(8'd2);
      clr = 1'b1;
      @(negedge clk);
      check("clr_hold_out_valid", out_valid, 1'b1);
      @(posedge clk);
      #1;
      clr = 1'b0;
      check("clr_hold_out_valid_after", out_valid, 1'b0);
      check("clr_hold_count_after", count, 3'd0);

      // Asynchronous reset mid-accumulation
      send(8'd1);
      send(8'd2);
      send(8'd3);
      #2;
      rst = 1'b1;
      #1;
      check("arst_count", count, 3'd0);
      check("arst_out_sum", out_sum, 8'd0);
      check("arst_out_valid", out_valid, 1'b0);
      check("arst_in_ready", in_ready, 1'b1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      push_exp(20);
      send(8'd5);
      send(8'd5);
      send(8'd5);
      send(8'd5);
      idle(1);

      // COUNT=1 instance: each operand is its own result
      c1_in_valid = 1'b1;
      c1_in_data  = 8'd77;
      @(negedge clk);
      check("c1_in_ready", c1_in_ready, 1'b1);
      @(posedge clk);
      #1;
      c1_in_valid = 1'b0;
      c1_in_data  = 8'hxx;
      @(negedge clk);
      check("c1_out_valid", c1_out_valid, 1'b1);
      check("c1_out_sum", c1_out_sum, 8'd77);
      check("c1_out_ovf", c1_out_ovf, 1'b0);
      check("c1_count", c1_count, 1'b1);
      @(posedge clk);
      #1;
      check("c1_out_valid_after", c1_out_valid, 1'b0);

      idle(2);
      check("wrap_results_outstanding", q_w.size(), 0);
      check("sat_results_outstanding", q_s.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
